// File: rtl/cam_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : cam_cfg_seq
// Description : Camera register-configuration sequencer. After reset it waits
//               for sensor power-up, then walks a register LUT and issues each
//               entry to an SCCB master over a req/done handshake. Entries whose
//               address byte is 8'hFF are delay markers (no bus transaction).
//               When the table is written, cfg_done rises and enables capture.
// Optional    : define CAM_CFG_READBACK_EN to read back each written register
//               (except NOCHK_ADDR), retry up to RETRY_MAX times on mismatch,
//               and stop in an error state when retries run out.
// Ports       : clk_i        system clock
//               rst_ni       asynchronous active-low reset
//               cfg_start_i  restart pulse (honoured in IDLE/DONE/ERR)
//               lut_addr_o   LUT index (registered)
//               lut_data_i   LUT entry {reg_addr, reg_data}, 1 cycle latency
//               req_o        SCCB request level
//               req_cmd_o    0 = write, 1 = read
//               req_addr_o   register address
//               req_wdata_o  write data
//               done_i       SCCB completion pulse
//               rdata_i      read data, valid with done_i on a read
//               cfg_busy_o   sequence in progress
//               cfg_done_o   table fully written
//               cfg_err_o    readback failure, sticky until restart
// Revision    : 1.0 - initial release
// ============================================================================
module cam_cfg_seq #(
  parameter int unsigned REG_NUM    = 52,
  parameter int unsigned PWR_DLY    = 1_000_000,
  parameter int unsigned SW_DLY     = 50_000,
  parameter int unsigned RETRY_MAX  = 3,
  parameter logic [7:0]  NOCHK_ADDR = 8'h12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_start_i,
  output logic [7:0]  lut_addr_o,
  input  logic [15:0] lut_data_i,
  output logic        req_o,
  output logic        req_cmd_o,
  output logic [7:0]  req_addr_o,
  output logic [7:0]  req_wdata_o,
  input  logic        done_i,
  input  logic [7:0]  rdata_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o
);

  // One counter serves both the power-up wait and delay-marker waits.
  localparam int unsigned PWR_W = $clog2(PWR_DLY + 1);
  localparam int unsigned SW_W  = $clog2(SW_DLY + 1);
  localparam int unsigned CNT_W = (PWR_W > SW_W) ? PWR_W : SW_W;
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       IDX_LAST = 8'(REG_NUM - 1);
  localparam logic [7:0]       DLY_MARK = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PWR_WAIT = 4'd1,
    S_FETCH    = 4'd2,
    S_LOAD     = 4'd3,
    S_WAIT_DLY = 4'd4,
    S_WRITE    = 4'd5,
    S_READ     = 4'd6,
    S_CHECK    = 4'd7,
    S_NEXT     = 4'd8,
    S_DONE     = 4'd9,
    S_ERR      = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       lut_addr_q, lut_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [7:0]       req_addr_q, req_addr_d;
  logic [7:0]       req_wdata_q, req_wdata_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_busy_q, cfg_busy_d;
  logic             restart;

`ifdef CAM_CFG_READBACK_EN
  localparam int unsigned RTRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RTRY_W-1:0] RTRY_MAX_C = RTRY_W'(RETRY_MAX);
  localparam logic [RTRY_W-1:0] RTRY_ONE   = RTRY_W'(1);

  logic              req_cmd_q, req_cmd_d;
  logic              cfg_err_q, cfg_err_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [7:0]        rdata_q, rdata_d;
`endif

  assign restart = cfg_start_i &&
                   ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lut_addr_d  = lut_addr_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cfg_done_d  = cfg_done_q;
`ifdef CAM_CFG_READBACK_EN
    req_cmd_d   = req_cmd_q;
    cfg_err_d   = cfg_err_q;
    retry_d     = retry_q;
    rdata_d     = rdata_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_PWR_WAIT;
        cnt_d   = '0;
      end
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d    = S_FETCH;
          idx_d      = 8'd0;
          lut_addr_d = 8'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // lut_addr already holds the index here; the ROM registers it at the
      // end of this cycle so the entry is valid during LOAD.
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (lut_data_i[15:8] == DLY_MARK) begin
          state_d = S_WAIT_DLY;
          cnt_d   = '0;
        end else begin
          state_d     = S_WRITE;
          req_d       = 1'b1;
          req_addr_d  = lut_data_i[15:8];
          req_wdata_d = lut_data_i[7:0];
`ifdef CAM_CFG_READBACK_EN
          req_cmd_d   = 1'b0;
          retry_d     = '0;
`endif
        end
      end
      S_WAIT_DLY: begin
        if (cnt_q == SW_LAST) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WRITE: begin
        if (req_q && done_i) begin
          req_d   = 1'b0;
          state_d = S_NEXT;
`ifdef CAM_CFG_READBACK_EN
          if (req_addr_q != NOCHK_ADDR) begin
            state_d   = S_READ;
            req_cmd_d = 1'b1;
          end
`endif
        end
      end
`ifdef CAM_CFG_READBACK_EN
      // First READ cycle has req low to keep an idle gap after the write.
      S_READ: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (done_i) begin
          req_d   = 1'b0;
          rdata_d = rdata_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rdata_q == req_wdata_q) begin
          retry_d = '0;
          state_d = S_NEXT;
        end else if (retry_q < RTRY_MAX_C) begin
          retry_d   = retry_q + RTRY_ONE;
          req_cmd_d = 1'b0;
          req_d     = 1'b1;
          state_d   = S_WRITE;
        end else begin
          cfg_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_ERR: state_d = S_ERR;
`endif
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d    = S_DONE;
          cfg_done_d = 1'b1;
        end else begin
          idx_d      = idx_q + 8'd1;
          lut_addr_d = idx_q + 8'd1;
          state_d    = S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // A restart skips the power-up wait: the sensor is already powered.
    if (restart) begin
      state_d    = S_FETCH;
      idx_d      = 8'd0;
      lut_addr_d = 8'd0;
      cfg_done_d = 1'b0;
`ifdef CAM_CFG_READBACK_EN
      cfg_err_d  = 1'b0;
      retry_d    = '0;
`endif
    end

    cfg_busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'd0;
      lut_addr_q  <= 8'd0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      req_addr_q  <= 8'd0;
      req_wdata_q <= 8'd0;
      cfg_done_q  <= 1'b0;
      cfg_busy_q  <= 1'b0;
`ifdef CAM_CFG_READBACK_EN
      req_cmd_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      retry_q     <= '0;
      rdata_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lut_addr_q  <= lut_addr_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cfg_done_q  <= cfg_done_d;
      cfg_busy_q  <= cfg_busy_d;
`ifdef CAM_CFG_READBACK_EN
      req_cmd_q   <= req_cmd_d;
      cfg_err_q   <= cfg_err_d;
      retry_q     <= retry_d;
      rdata_q     <= rdata_d;
`endif
    end
  end

  assign lut_addr_o  = lut_addr_q;
  assign req_o       = req_q;
  assign req_addr_o  = req_addr_q;
  assign req_wdata_o = req_wdata_q;
  assign cfg_done_o  = cfg_done_q;
  assign cfg_busy_o  = cfg_busy_q;

`ifdef CAM_CFG_READBACK_EN
  assign req_cmd_o = req_cmd_q;
  assign cfg_err_o = cfg_err_q;
`else
  // Without readback the bus is write-only and no error can occur.
  logic [7:0] unused_readback;
  assign unused_readback = rdata_i ^ NOCHK_ADDR ^ 8'(RETRY_MAX);
  assign req_cmd_o = 1'b0;
  assign cfg_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_cfg_seq
// Description : Directed self-checking bench for cam_cfg_seq with a small
//               synchronous LUT ROM and an SCCB responder that answers each
//               request 5 cycles after req rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_cfg_seq;

  localparam int REG_NUM   = 3;
  localparam int PWR_DLY   = 10;
  localparam int SW_DLY    = 7;
  localparam int RETRY_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data = 16'h0000;
  logic        req, req_cmd;
  logic [7:0]  req_addr, req_wdata;
  logic        done = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        cfg_busy, cfg_done, cfg_err;

  logic [15:0] rom [0:255];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction log written by the responder.
  int         n_log = 0;
  logic       log_cmd   [0:255];
  logic [7:0] log_addr  [0:255];
  logic [7:0] log_wdata [0:255];
  int         log_cyc   [0:255];

  int   rcnt = 0;
  int   rmode = 0;
  logic mm_used = 1'b0;
  logic bad_read;

  cam_cfg_seq #(
    .REG_NUM   (REG_NUM),
    .PWR_DLY   (PWR_DLY),
    .SW_DLY    (SW_DLY),
    .RETRY_MAX (RETRY_MAX),
    .NOCHK_ADDR(8'h12)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_start_i(cfg_start),
    .lut_addr_o (lut_addr),
    .lut_data_i (lut_data),
    .req_o      (req),
    .req_cmd_o  (req_cmd),
    .req_addr_o (req_addr),
    .req_wdata_o(req_wdata),
    .done_i     (done),
    .rdata_i    (rdata),
    .cfg_busy_o (cfg_busy),
    .cfg_done_o (cfg_done),
    .cfg_err_o  (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) lut_data <= rom[lut_addr];

  assign bad_read = (rmode == 1 && req_addr == 8'h44) ||
                    (rmode == 2 && !mm_used && req_addr == 8'h55);

  // SCCB responder: done is high in the 5th cycle after req is first seen high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      rcnt <= 0;
    end else begin
      done <= 1'b0;
      if (rmode != 2) mm_used <= 1'b0;
      if (req && !done) begin
        if (rcnt == 4) begin
          done <= 1'b1;
          rcnt <= 0;
          if (req_cmd) begin
            rdata <= req_wdata ^ {7'd0, bad_read};
            if (rmode == 2 && req_addr == 8'h55) mm_used <= 1'b1;
          end
          log_cmd[n_log]   <= req_cmd;
          log_addr[n_log]  <= req_addr;
          log_wdata[n_log] <= req_wdata;
          log_cyc[n_log]   <= cyc + 1;
          n_log            <= n_log + 1;
        end else begin
          rcnt <= rcnt + 1;
        end
      end else begin
        rcnt <= 0;
      end
    end
  end

  function automatic int count_tx(input int base, input logic cmd, input logic [7:0] addr);
    int n = 0;
    for (int i = base; i < n_log; i++)
      if (log_cmd[i] == cmd && log_addr[i] == addr) n++;
    return n;
  endfunction

  // Edges until req is seen high (#1 after the edge); -1 on timeout.
  task automatic count_to_req(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk); #1;
      n++;
      if (req) return;
    end
    n = -1;
  endtask

  task automatic wait_end(input int maxc, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req, req_cmd, cfg_busy, cfg_done, cfg_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {req, req_cmd, cfg_busy, cfg_done, cfg_err});
    end
    checks++;
    if ({lut_addr, req_addr, req_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 000000", {lut_addr, req_addr, req_wdata});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_busy: got %b expected 0", cfg_busy);
    end
  endtask

  task automatic test_power_up();
    int  n, t, base, m, nw;
    bit  ok;
    logic [7:0] wa [0:7];
    logic [7:0] wd [0:7];
    rom[0] = 16'h0A55;
    rom[1] = 16'h12C3;
    rom[2] = 16'h7F0E;
    base = n_log;
    @(posedge clk); #1;
    m = cyc;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL pwr_busy: got %b expected 1", cfg_busy);
    end
    count_to_req(60, n);
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL pwr_req_latency: got %0d expected 12", n);
    end
    wait_end(500, ok, t);
    checks++;
    if (!ok || cfg_done !== 1'b1 || cfg_busy !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL pwr_end_state: got ok=%0d done=%b busy=%b err=%b expected ok=1 done=1 busy=0 err=0",
               ok, cfg_done, cfg_busy, cfg_err);
    end
    nw = 0;
    for (int i = base; i < n_log; i++) begin
      if (log_cmd[i] == 1'b0) begin
        if (nw < 8) begin
          wa[nw] = log_addr[i];
          wd[nw] = log_wdata[i];
        end
        nw++;
      end
    end
    checks++;
    if (nw != 3) begin
      errors++;
      $display("FAIL pwr_write_count: got %0d expected 3", nw);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wa[k] !== rom[k][15:8] || wd[k] !== rom[k][7:0]) begin
          errors++;
          $display("FAIL pwr_write_%0d: got %h%h expected %h", k, wa[k], wd[k], rom[k]);
        end
      end
    end
    checks++;
    if (lut_addr !== 8'd2) begin
      errors++;
      $display("FAIL pwr_last_index: got %0d expected 2", lut_addr);
    end
`ifndef CAM_CFG_READBACK_EN
    checks++;
    if (log_cyc[base] - m != 18) begin
      errors++;
      $display("FAIL pwr_first_done: got %0d expected 18", log_cyc[base] - m);
    end
    checks++;
    if (log_cyc[base + 1] - log_cyc[base] != 9) begin
      errors++;
      $display("FAIL entry_spacing: got %0d expected 9", log_cyc[base + 1] - log_cyc[base]);
    end
    checks++;
    if (t - log_cyc[base + 2] != 2) begin
      errors++;
      $display("FAIL cfg_done_latency: got %0d expected 2", t - log_cyc[base + 2]);
    end
`endif
  endtask

  task automatic test_delay_marker_restart();
    int n, t, base;
    bit ok;
    rom[0] = 16'h2001;
    rom[1] = 16'hFF00;
    rom[2] = 16'h3302;
    base = n_log;
    pulse_start();
    checks++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b1 || lut_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_state: got done=%b busy=%b idx=%0d expected done=0 busy=1 idx=0",
               cfg_done, cfg_busy, lut_addr);
    end
    count_to_req(30, n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL restart_req_latency: got %0d expected 2", n);
    end
    wait_end(500, ok, t);
    checks++;
    if (!ok || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL marker_end: got ok=%0d done=%b expected ok=1 done=1", ok, cfg_done);
    end
    checks++;
    if (count_tx(base, 1'b0, 8'h20) != 1 || count_tx(base, 1'b0, 8'h33) != 1 ||
        count_tx(base, 1'b0, 8'hFF) != 0) begin
      errors++;
      $display("FAIL marker_writes: got 20:%0d 33:%0d FF:%0d expected 1 1 0",
               count_tx(base, 1'b0, 8'h20), count_tx(base, 1'b0, 8'h33), count_tx(base, 1'b0, 8'hFF));
    end
`ifndef CAM_CFG_READBACK_EN
    checks++;
    if (log_cyc[base + 1] - log_cyc[base] != 19 || log_wdata[base + 1] !== 8'h02) begin
      errors++;
      $display("FAIL marker_gap: got %0d data %h expected 19 data 02",
               log_cyc[base + 1] - log_cyc[base], log_wdata[base + 1]);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int n, t, base;
    bit ok;
    base = n_log;
    pulse_start();
    count_to_req(30, n);
    pulse_start();
    checks++;
    if (req !== 1'b1 || lut_addr !== 8'd0 || cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_write: got req=%b idx=%0d busy=%b expected req=1 idx=0 busy=1",
               req, lut_addr, cfg_busy);
    end
    wait_end(500, ok, t);
    checks++;
    if (!ok || count_tx(base, 1'b0, 8'h20) != 1 || count_tx(base, 1'b0, 8'h33) != 1) begin
      errors++;
      $display("FAIL start_ignored_writes: got ok=%0d 20:%0d 33:%0d expected ok=1 1 1",
               ok, count_tx(base, 1'b0, 8'h20), count_tx(base, 1'b0, 8'h33));
    end
  endtask

  task automatic test_async_reset();
    int n, t;
    bit ok;
    pulse_start();
    count_to_req(30, n);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req, cfg_busy, cfg_done, cfg_err, req_cmd} !== 5'b0 || {lut_addr, req_addr, req_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: got req=%b busy=%b addr=%h expected all zero",
               req, cfg_busy, req_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_to_req(60, n);
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL async_reset_pwr_wait: got %0d expected 13", n);
    end
    wait_end(500, ok, t);
    checks++;
    if (!ok || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_end: got ok=%0d done=%b expected ok=1 done=1", ok, cfg_done);
    end
  endtask

`ifdef CAM_CFG_READBACK_EN
  task automatic test_retry_exhaust();
    int t, base;
    bit ok;
    rom[0] = 16'h4410;
    rom[1] = 16'h5520;
    rom[2] = 16'h6630;
    rmode = 1;
    base = n_log;
    pulse_start();
    wait_end(2000, ok, t);
    checks++;
    if (!ok || cfg_err !== 1'b1 || cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL retry_end: got ok=%0d err=%b done=%b busy=%b expected ok=1 err=1 done=0 busy=0",
               ok, cfg_err, cfg_done, cfg_busy);
    end
    checks++;
    if (count_tx(base, 1'b0, 8'h44) != 4 || count_tx(base, 1'b1, 8'h44) != 4 ||
        count_tx(base, 1'b0, 8'h55) != 0) begin
      errors++;
      $display("FAIL retry_counts: got w=%0d r=%0d w55=%0d expected 4 4 0",
               count_tx(base, 1'b0, 8'h44), count_tx(base, 1'b1, 8'h44), count_tx(base, 1'b0, 8'h55));
    end
  endtask

  task automatic test_nochk_retry();
    int t, base;
    bit ok;
    rom[0] = 16'h1280;
    rom[1] = 16'h5520;
    rom[2] = 16'h6630;
    rmode = 2;
    base = n_log;
    pulse_start();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", cfg_err);
    end
    wait_end(2000, ok, t);
    checks++;
    if (!ok || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL nochk_end: got ok=%0d done=%b err=%b expected ok=1 done=1 err=0", ok, cfg_done, cfg_err);
    end
    checks++;
    if (count_tx(base, 1'b0, 8'h12) != 1 || count_tx(base, 1'b1, 8'h12) != 0) begin
      errors++;
      $display("FAIL nochk_counts: got w=%0d r=%0d expected 1 0",
               count_tx(base, 1'b0, 8'h12), count_tx(base, 1'b1, 8'h12));
    end
    checks++;
    if (count_tx(base, 1'b0, 8'h55) != 2 || count_tx(base, 1'b1, 8'h55) != 2 ||
        count_tx(base, 1'b1, 8'h66) != 1) begin
      errors++;
      $display("FAIL one_retry_counts: got w55=%0d r55=%0d r66=%0d expected 2 2 1",
               count_tx(base, 1'b0, 8'h55), count_tx(base, 1'b1, 8'h55), count_tx(base, 1'b1, 8'h66));
    end
    rmode = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    test_reset();
    test_power_up();
    test_delay_marker_restart();
    test_start_ignored();
    test_async_reset();
`ifdef CAM_CFG_READBACK_EN
    test_retry_exhaust();
    test_nochk_retry();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_cfg_seq.md
# cam_cfg_seq

Camera register-configuration sequencer. It runs in the system clock domain and walks a register look-up table after reset (or on request). Each entry is issued to the SCCB master through a req/done handshake. When the whole table is written, it raises `cfg_done`, which drives the `enable` input of the pixel capture block.

## Interface
Parameters:
- `REG_NUM`, 52: number of LUT entries, indices 0..REG_NUM-1.
- `PWR_DLY`, 1_000_000: power-up wait in clk cycles (20 ms @ 50 MHz).
- `SW_DLY`, 50_000: wait in cycles for a delay-marker entry.
- `RETRY_MAX`, 3: write retries per entry. Readback build only.
- `NOCHK_ADDR`, 8'h12: register address excluded from readback (self-clearing soft-reset bit).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: one-cycle pulse; restarts the sequence from index 0.
- `lut_addr` out 8: LUT index, registered.
- `lut_data` in 16: LUT entry {reg_addr[15:8], reg_data[7:0]}. Valid 1 cycle after `lut_addr` changes.
- `req` out 1: transaction request to SCCB master, level.
- `req_cmd` out 1: 0 = write, 1 = read.
- `req_addr` out 8: register address.
- `req_wdata` out 8: write data.
- `done` in 1: one-cycle pulse from SCCB master when the transaction completes.
- `rdata` in 8: read data, valid with `done` on a read.
- `cfg_busy` out 1: sequence in progress.
- `cfg_done` out 1: table fully written; level; feeds capture `enable`.
- `cfg_err` out 1: readback failure, sticky until restart.

## Operation
- States: IDLE, PWR_WAIT, FETCH, LOAD, WAIT_DLY, WRITE, READ, CHECK, NEXT, DONE, ERR.
- Reset: all outputs 0 and state IDLE. The first cycle after `rst_n` release goes IDLE→PWR_WAIT automatically.
- PWR_WAIT:
  - Stays exactly `PWR_DLY` cycles; the counter is sized `$clog2(PWR_DLY+1)`.
  - Then goes to FETCH with index 0.
- FETCH: drives `lut_addr` = index, then goes to LOAD, which waits one cycle for ROM latency.
- LOAD:
  - If `lut_data[15:8]`==8'hFF (delay marker): go to WAIT_DLY for `SW_DLY` cycles, then NEXT.
  - Otherwise: latch `req_addr`/`req_wdata`, set `req_cmd`=0, `req`=1, and go to WRITE.
- WRITE: `req` is held until `done` is sampled high. `req` drops the cycle after `done`.
- NEXT:
  - If index==REG_NUM-1, go to DONE.
  - Otherwise increment the index and go to FETCH.
- DONE: `cfg_done`=1 and `cfg_busy`=0. The state holds until `cfg_start`.
- `cfg_start` in DONE, ERR or IDLE:
  - Clears `cfg_done` and `cfg_err`.
  - Index goes to 0 and the next state is FETCH; PWR_WAIT is skipped.
- `cfg_start` in any other state is ignored.
- `cfg_busy`=1 in every state except IDLE, DONE and ERR.
- `done` received while `req`=0 is ignored.
- Index counter is 8 bits wide. `REG_NUM` must be ≤256; there is no wrap past REG_NUM-1.

## Timing
- `req` is asserted in the cycle after LOAD. `req`, `req_cmd`, `req_addr` and `req_wdata` are stable while `req`=1.
- Minimum one idle cycle (`req`=0) between consecutive transactions.
- Per-entry overhead excluding SCCB time: FETCH + LOAD + NEXT = 3 cycles.
- `cfg_done` rises 2 cycles after the `done` of the last entry (NEXT, then DONE).
- Asynchronous reset mid-transaction:
  - `req` drops immediately.
  - The sequence restarts with full PWR_WAIT.
  - The SCCB master must tolerate an aborted request.

## Configuration
- Macro `CAM_CFG_READBACK_EN`.
- Defined:
  - After WRITE's `done`, if `req_addr`≠`NOCHK_ADDR`: go to READ. READ issues `req_cmd`=1 to the same address with the same handshake.
  - On `done`, `rdata` is registered, then CHECK.
  - CHECK on match: go to NEXT and clear the retry count.
  - CHECK on mismatch with retry count < `RETRY_MAX`: increment the count and re-enter WRITE for the same entry.
  - CHECK on mismatch with retries exhausted: go to ERR. `cfg_err`=1, `cfg_done` stays 0, `cfg_busy`=0.
- Undefined:
  - READ, CHECK and ERR are not built; `rdata` is unused.
  - `req_cmd` is tied 0 and `cfg_err` is tied 0.

## Test plan
- Reset release, `PWR_DLY`=10, `REG_NUM`=3, `done` 5 cycles after each `req` -> exactly 10 PWR_WAIT cycles. Then 3 writes with (addr, data) matching the LUT, `cfg_done`=1 2 cycles after the 3rd `done`, `cfg_busy` low.
- Entry 1 = 16'hFF00, `SW_DLY`=7 -> no `req` for that entry, 7-cycle gap, entry 2 proceeds.
- `cfg_start` pulse in DONE -> `cfg_done` clears next cycle, index restarts at 0 with no PWR_WAIT. `cfg_start` during WRITE -> no effect.
- `rst_n` low while `req`=1 -> `req` and all outputs 0 asynchronously. After release, full PWR_WAIT is repeated.
- `CAM_CFG_READBACK_EN`, `rdata`=wdata^1 on entry 0 for all reads, `RETRY_MAX`=3 -> 4 write/read pairs on addr 0, then `cfg_err`=1, `cfg_done`=0.
- `CAM_CFG_READBACK_EN`, entry addr 8'h12 -> write only, no read issued. Mismatch on the first read of another entry then match -> one retry, sequence completes, `cfg_err`=0.
